// File: rtl/pipelined_tree_multiplier.sv
// pipelined_tree_multiplier
//   WIDTH x WIDTH multiplier built as a binary adder tree of partial products.
//   Stage 0 registers the operands, mode, tag and valid bit. Each of the
//   LEVELS = log2(WIDTH) adder levels is registered, and the last level drives
//   P directly. Signed and unsigned modes are selected per operation. A
//   single global enable stalls the whole pipe when the output is blocked.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all valid, data and tag state
//   in_valid   operand pair present         in_ready   block accepts this cycle
//   signed_i   1 = two's complement operands
//   A, B       WIDTH-bit operands           in_tag     sideband tag
//   out_valid  P/out_tag hold a result      out_ready  consumer accepts result
//   P          2*WIDTH-bit product          out_tag    tag paired with P
//   busy       OR of all stage valid bits
module pipelined_tree_multiplier #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned PW     = 2 * WIDTH;

  logic               en;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sgn_q;
  logic [LEVELS:0]    vld_q;
  logic [TAG_W-1:0]   tag_q [LEVELS+1];
  logic [PW-1:0]      pp    [WIDTH];

  // Heap-ordered tree registers: node i sums its children 2i and 2i+1.
  // Indices WIDTH/2..WIDTH-1 form the first level (children are partial
  // products); node 1 is the root and is the final product.
  logic [PW-1:0]      node  [1:WIDTH-1];

  assign out_valid = vld_q[LEVELS];
  assign en        = ~(out_valid & ~out_ready);
  assign in_ready  = en;
  assign busy      = |vld_q;
  assign P         = node[1];
  assign out_tag   = tag_q[LEVELS];

  // Partial products from the stage-0 operands. In signed mode the
  // multiplicand is sign-extended and the MSB row carries weight -2^(W-1),
  // so it is subtracted instead of added.
  always_comb begin
    logic [PW-1:0] a_ext;
    a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pp[i] = b_q[i] ? (a_ext << i) : '0;
    end
    if (sgn_q && b_q[WIDTH-1]) begin
      pp[WIDTH-1] = '0 - (a_ext << (WIDTH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      vld_q <= '0;
      for (int unsigned k = 0; k <= LEVELS; k++) begin
        tag_q[k] <= '0;
      end
      for (int unsigned i = 1; i < WIDTH; i++) begin
        node[i] <= '0;
      end
    end else if (en) begin
      a_q      <= A;
      b_q      <= B;
      sgn_q    <= signed_i;
      vld_q    <= {vld_q[LEVELS-1:0], in_valid};
      tag_q[0] <= in_tag;
      for (int unsigned k = 1; k <= LEVELS; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      for (int unsigned i = WIDTH / 2; i < WIDTH; i++) begin
        node[i] <= pp[2*i-WIDTH] + pp[2*i-WIDTH+1];
      end
      for (int unsigned i = 1; i < WIDTH / 2; i++) begin
        node[i] <= node[2*i] + node[2*i+1];
      end
    end
  end

endmodule
